// File: rtl/imem_prog_if.sv
// Program-load stream between the host loader (master) and the instruction memory (slave).
interface imem_prog_if #(
  parameter int unsigned PC_W   = 8,
  parameter int unsigned INST_W = 9
);
  logic              ld_start;
  logic              ld_valid;
  logic [INST_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic [PC_W:0]     ld_count;
  logic              ld_err;

  modport master (
    output ld_start, ld_valid, ld_data, ld_last,
    input  ld_ready, ld_count, ld_err
  );

  modport slave (
    input  ld_start, ld_valid, ld_data, ld_last,
    output ld_ready, ld_count, ld_err
  );
endinterface

// File: rtl/imem_prog.sv
// Writable instruction memory: wiped to HALT_OP after reset, loaded over a valid/ready
// stream, and read by the fetch stage with one cycle of latency.
module imem_prog #(
  parameter int unsigned       PC_W    = 8,
  parameter int unsigned       INST_W  = 9,
  parameter int unsigned       DEPTH   = 256,
  parameter logic [INST_W-1:0] HALT_OP = '1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [PC_W-1:0]   i_pc,
  output logic [INST_W-1:0] o_inst,
  output logic              o_fetch_ok,
  imem_prog_if.slave        ld_if
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PC_W-1:0] LAST_ADDR = PC_W'(DEPTH - 1);

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;

  logic [INST_W-1:0] r_mem [DEPTH];
  logic [1:0]        r_state;
  logic [PC_W-1:0]   r_clr_ptr;
  logic [PC_W-1:0]   r_ld_ptr;
  logic [PC_W:0]     r_ld_count;
  logic              r_ld_err;
  logic              r_fetch_ok;
  logic [INST_W-1:0] r_inst;

  logic              w_accept;
  logic              w_we;
  logic [AW-1:0]     w_waddr;
  logic [INST_W-1:0] w_wdata;
  logic              w_pc_ok;

  assign w_accept = (r_state == S_LOAD) && ld_if.ld_valid;
  assign w_pc_ok  = (32'(i_pc) < DEPTH);

  // Single write port shared by the wipe and the loader; they never overlap.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_clr_ptr[AW-1:0];
    w_wdata = HALT_OP;
    if (!i_reset) begin
      if (r_state == S_CLEAR) begin
        w_we = 1'b1;
      end else if (w_accept) begin
        w_we    = 1'b1;
        w_waddr = r_ld_ptr[AW-1:0];
        w_wdata = ld_if.ld_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_CLEAR;
      r_clr_ptr  <= '0;
      r_ld_ptr   <= '0;
      r_ld_count <= '0;
      r_ld_err   <= 1'b0;
      r_fetch_ok <= 1'b0;
      r_inst     <= HALT_OP;
    end else begin
      // inst and fetch_ok come from the same state so they are always coherent.
      r_fetch_ok <= (r_state == S_RUN);
      r_inst     <= ((r_state == S_RUN) && w_pc_ok) ? r_mem[i_pc[AW-1:0]] : HALT_OP;
      case (r_state)
        S_CLEAR: begin
          if (r_clr_ptr == LAST_ADDR) begin
            r_clr_ptr <= '0;
            r_state   <= S_RUN;
          end else begin
            r_clr_ptr <= r_clr_ptr + 1'b1;
          end
        end
        S_RUN: begin
          if (ld_if.ld_start) begin
            r_state    <= S_LOAD;
            r_ld_ptr   <= '0;
            r_ld_count <= '0;
            r_ld_err   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (ld_if.ld_valid) begin
            r_ld_count <= r_ld_count + 1'b1;
            if (r_ld_ptr != LAST_ADDR) r_ld_ptr <= r_ld_ptr + 1'b1;
            if (ld_if.ld_last) begin
              r_state <= S_RUN;
            end else if (r_ld_ptr == LAST_ADDR) begin
              r_ld_err <= 1'b1;
              r_state  <= S_RUN;
            end
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

  assign o_inst         = r_inst;
  assign o_fetch_ok     = r_fetch_ok;
  assign ld_if.ld_ready = (r_state == S_LOAD);
  assign ld_if.ld_count = r_ld_count;
  assign ld_if.ld_err   = r_ld_err;

endmodule

// File: tb/tb_imem_prog.sv
// Directed bench for imem_prog: a DEPTH=256 instance for wipe/load/fetch and a DEPTH=16
// instance for the overflow case.
module tb_imem_prog;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [7:0] pc_a, pc_b;
  logic [8:0] inst_a, inst_b;
  logic       ok_a, ok_b;

  imem_prog_if #(.PC_W(8), .INST_W(9)) bus_a ();
  imem_prog_if #(.PC_W(8), .INST_W(9)) bus_b ();

  imem_prog #(.PC_W(8), .INST_W(9), .DEPTH(256), .HALT_OP(9'h1FF)) u_dut (
    .i_clk      (clk),
    .i_reset    (rst_a),
    .i_pc       (pc_a),
    .o_inst     (inst_a),
    .o_fetch_ok (ok_a),
    .ld_if      (bus_a.slave)
  );

  imem_prog #(.PC_W(8), .INST_W(9), .DEPTH(16), .HALT_OP(9'h1FF)) u_dut16 (
    .i_clk      (clk),
    .i_reset    (rst_b),
    .i_pc       (pc_b),
    .o_inst     (inst_b),
    .o_fetch_ok (ok_b),
    .ld_if      (bus_b.slave)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [8:0] prog    [32];
  logic [8:0] exp_mem [256];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with fetch_ok low after reset release, pulsing ld_start for the first
  // 'poke' cycles of the wipe.
  task automatic wait_run(input int poke, output int zeros);
    zeros = 0;
    for (int i = 0; i < 400; i++) begin
      bus_a.ld_start = (i < poke);
      tick();
      if (ok_a) break;
      zeros++;
    end
    bus_a.ld_start = 1'b0;
  endtask

  task automatic load_a(input int n, input bit with_last, input bit gaps, input int poke_at,
                        output int beats);
    beats = 0;
    bus_a.ld_start = 1'b1;
    tick();
    bus_a.ld_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        for (int g = 0; g < 3; g++) begin
          if ($urandom_range(0, 1) == 0) break;
          bus_a.ld_valid = 1'b0;
          bus_a.ld_data  = 9'h155;
          bus_a.ld_last  = 1'b1;
          tick();
        end
      end
      bus_a.ld_valid = 1'b1;
      bus_a.ld_data  = prog[i];
      bus_a.ld_last  = with_last && (i == n - 1);
      bus_a.ld_start = (i == poke_at);
      tick();
      beats++;
      exp_mem[i] = prog[i];
    end
    bus_a.ld_valid = 1'b0;
    bus_a.ld_last  = 1'b0;
    bus_a.ld_start = 1'b0;
  endtask

  task automatic rd_a(input string tag, input int pc, input logic [8:0] exp);
    pc_a = 8'(pc);
    tick();
    chk(tag, {23'd0, inst_a}, {23'd0, exp});
  endtask

  initial begin
    int zeros, beats, acc;
    logic rdy16;

    rst_a = 1'b1; rst_b = 1'b1; pc_a = '0; pc_b = '0;
    bus_a.ld_start = 0; bus_a.ld_valid = 0; bus_a.ld_data = '0; bus_a.ld_last = 0;
    bus_b.ld_start = 0; bus_b.ld_valid = 0; bus_b.ld_data = '0; bus_b.ld_last = 0;

    // Reset held 300 cycles, then the wipe must take exactly 256 cycles.
    for (int i = 0; i < 300; i++) tick();
    chk("rst_inst", {23'd0, inst_a}, 32'h1FF);
    chk("rst_ok", {31'd0, ok_a}, 0);
    chk("rst_ready", {31'd0, bus_a.ld_ready}, 0);
    chk("rst_count", {23'd0, bus_a.ld_count}, 0);
    chk("rst_err", {31'd0, bus_a.ld_err}, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    wait_run(0, zeros);
    chk("clear_len", zeros, 256);
    for (int p = 0; p < 256; p++) begin
      exp_mem[p] = 9'h1FF;
      rd_a("clear_word", p, 9'h1FF);
    end

    // 25-word program, ld_start poked on word 10 must be ignored.
    for (int i = 0; i < 25; i++)
      prog[i] = (i < 7) ? 9'(i) : (i == 7) ? 9'h100 : (i == 24) ? 9'h1FF : 9'(9'h040 + i);
    load_a(25, 1'b1, 1'b0, 10, beats);
    chk("ok_lag", {31'd0, ok_a}, 0);
    chk("ld_ready_done", {31'd0, bus_a.ld_ready}, 0);
    chk("ld_count25", {23'd0, bus_a.ld_count}, 25);
    chk("ld_err25", {31'd0, bus_a.ld_err}, 0);
    tick();
    chk("ok_back", {31'd0, ok_a}, 1);
    rd_a("pc7_add", 7, 9'h100);
    rd_a("pc24_halt", 24, 9'h1FF);
    rd_a("pc3_push", 3, 9'h003);
    rd_a("pc10_poked", 10, 9'h04A);
    rd_a("pc25_old", 25, 9'h1FF);

    // Load with idle gaps (ld_last=1 on idle beats must not end the load).
    for (int i = 0; i < 12; i++) prog[i] = 9'(9'h0C0 + i);
    load_a(12, 1'b1, 1'b1, -1, beats);
    chk("gap_count", {23'd0, bus_a.ld_count}, 32'(beats));
    chk("gap_count12", {23'd0, bus_a.ld_count}, 12);
    tick();
    for (int p = 0; p < 26; p++) rd_a("gap_word", p, exp_mem[p]);

    // Reset after 10 of 25 words: wipe restarts and ignores ld_start.
    for (int i = 0; i < 25; i++) prog[i] = 9'(9'h0A0 + i);
    load_a(10, 1'b0, 1'b0, -1, beats);
    chk("mid_ready", {31'd0, bus_a.ld_ready}, 1);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    chk("mid_rst_count", {23'd0, bus_a.ld_count}, 0);
    chk("mid_rst_ok", {31'd0, ok_a}, 0);
    chk("mid_rst_ready", {31'd0, bus_a.ld_ready}, 0);
    wait_run(5, zeros);
    chk("reclear_len", zeros, 256);
    chk("reclear_count", {23'd0, bus_a.ld_count}, 0);
    chk("reclear_ready", {31'd0, bus_a.ld_ready}, 0);
    for (int p = 0; p < 256; p++) rd_a("reclear_word", p, 9'h1FF);

    // DEPTH=16 overflow: 20 beats without ld_last.
    bus_b.ld_start = 1'b1;
    tick();
    bus_b.ld_start = 1'b0;
    acc = 0;
    rdy16 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 16) rdy16 = bus_b.ld_ready;
      if (bus_b.ld_ready) acc++;
      bus_b.ld_valid = 1'b1;
      bus_b.ld_data  = 9'(9'h020 + i);
      bus_b.ld_last  = 1'b0;
      tick();
    end
    bus_b.ld_valid = 1'b0;
    chk("ovf_accepted", acc, 16);
    chk("ovf_ready", {31'd0, rdy16}, 0);
    chk("ovf_count", {23'd0, bus_b.ld_count}, 16);
    chk("ovf_err", {31'd0, bus_b.ld_err}, 1);
    chk("ovf_ok", {31'd0, ok_b}, 1);
    pc_b = 8'd20; tick();
    chk("ovf_pc20", {23'd0, inst_b}, 32'h1FF);
    pc_b = 8'd15; tick();
    chk("ovf_pc15", {23'd0, inst_b}, 32'h02F);
    pc_b = 8'd0; tick();
    chk("ovf_pc0", {23'd0, inst_b}, 32'h020);
    bus_b.ld_start = 1'b1;
    tick();
    bus_b.ld_start = 1'b0;
    chk("restart_err", {31'd0, bus_b.ld_err}, 0);
    chk("restart_count", {23'd0, bus_b.ld_count}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
